// File: rtl/dm_pkg.sv
// Shared constants and types for the data-memory store controller.
// Holds the store-width funct3 encodings and the controller state enum.
package dm_pkg;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/dm_store_ctrl_if.sv
// Data-memory write request bus between store controller and memory.
// master: drives valid/addr/wdata/web, samples ready. slave: the reverse.
interface dm_store_ctrl_if;

  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_web;

  modport master (
    output dm_req_valid,
    output dm_addr,
    output dm_wdata,
    output dm_web,
    input  dm_req_ready
  );

  modport slave (
    input  dm_req_valid,
    input  dm_addr,
    input  dm_wdata,
    input  dm_web,
    output dm_req_ready
  );

endinterface

// File: rtl/store_align.sv
// Store lane alignment: replicates data across lanes, builds byte strobes.
// Ports: funct3_i, addr_i[1:0], data_i -> wdata_o, web_o, legal_o.
module store_align
  import dm_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  web_o,
  output logic        legal_o
);

  always_comb begin
    wdata_o = '0;
    web_o   = '0;
    legal_o = 1'b0;
    unique case (1'b1)
      (funct3_i == F3_SB): begin
        wdata_o = {4{data_i[7:0]}};
        web_o   = 4'b0001 << addr_i;
        legal_o = 1'b1;
      end
      (funct3_i == F3_SH): begin
        wdata_o = {2{data_i[15:0]}};
        web_o   = 4'b0011 << {addr_i[1], 1'b0};
        legal_o = ~addr_i[0];
      end
      (funct3_i == F3_SW): begin
        wdata_o = data_i;
        web_o   = 4'b1111;
        legal_o = (addr_i == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_store_ctrl.sv
// MEM-stage store controller: aligns a store, issues it to data memory.
// Ports: clk, reset, st_* store in, CSR_reset flush, dm bus (master),
// dm_stall pipeline hold, st_done / st_fault one-cycle pulses.
module dm_store_ctrl
  import dm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [2:0]             st_funct3,
  input  logic                   CSR_reset,
  dm_store_ctrl_if.master        dm,
  output logic                   dm_stall,
  output logic                   st_done,
  output logic                   st_fault
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       web_q, web_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  logic [31:0] al_wdata;
  logic [3:0]  al_web;
  logic        al_legal;
  logic        take, reject, timeout_hit, fin;

  store_align u_align (
    .funct3_i (st_funct3),
    .addr_i   (st_addr[1:0]),
    .data_i   (st_data),
    .wdata_o  (al_wdata),
    .web_o    (al_web),
    .legal_o  (al_legal)
  );

  assign take   = (state_q == S_IDLE) & st_valid
                & al_legal & ~CSR_reset;
  assign reject = (state_q == S_IDLE) & st_valid
                & ~al_legal & ~CSR_reset;
  assign timeout_hit = TO_EN & (state_q == S_ISSUE)
                     & ~dm.dm_req_ready & (cnt_q == CNT_LAST);
  // ready wins over a same-cycle timeout
  assign fin = (state_q == S_ISSUE)
             & (dm.dm_req_ready | timeout_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      web_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      web_q   <= web_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = S_ISSUE;
      S_ISSUE: if (fin)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    web_d    = web_q;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    dm_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        dm_stall = take;
        cnt_d    = '0;
        fault_d  = reject;
        if (take) begin
          valid_d = 1'b1;
          addr_d  = {st_addr[31:2], 2'b00};
          wdata_d = al_wdata;
          web_d   = al_web;
        end
      end
      S_ISSUE: begin
        dm_stall = ~dm.dm_req_ready & ~timeout_hit;
        if (fin) begin
          valid_d = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          web_d   = '0;
          cnt_d   = '0;
          done_d  = dm.dm_req_ready;
          fault_d = ~dm.dm_req_ready;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign dm.dm_req_valid = valid_q;
  assign dm.dm_addr      = addr_q;
  assign dm.dm_wdata     = wdata_q;
  assign dm.dm_web       = web_q;
  assign st_done         = done_q;
  assign st_fault        = fault_q;

endmodule

// File: doc/dm_store_ctrl.md
DM_STORE_CTRL -- requirements
Module: dm_store_ctrl

Interface
REQ-001 SHALL expose parameter TIMEOUT_CYCLES, default 255: max ISSUE cycles without dm_req_ready (0 = no timeout).
REQ-002 SHALL expose parameter CNT_W, default 8: width of timeout counter, >= clog2(TIMEOUT_CYCLES+1).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 st_valid  in  1  MEM-stage store present this cycle.
REQ-007 st_addr  in  32  store byte address.
REQ-008 st_data  in  32  rs2 / fs2 store data, LSB-justified.
REQ-009 st_funct3  in  3  store width: 0 SB, 1 SH, 2 SW/FSW.
REQ-010 CSR_reset  in  1  pipeline flush from CSR unit.
REQ-011 dm_req_ready  in  1  data memory accepts write this cycle.
REQ-012 dm_req_valid  out  1  write request to data memory.
REQ-013 dm_addr  out  32  word-aligned address {st_addr[31:2],2'b00}.
REQ-014 dm_wdata  out  32  lane-replicated write data.
REQ-015 dm_web  out  4  byte write strobes, active-high, bit i = byte lane i.
REQ-016 dm_stall  out  1  holds pipeline while store is pending.
REQ-017 st_done  out  1  one-cycle pulse, store written.
REQ-018 st_fault  out  1  one-cycle pulse, misaligned/illegal store or timeout.

Function
REQ-019 SB SHALL give dm_web = 4'b0001 << st_addr[1:0], dm_wdata = {4{st_data[7:0]}}.
REQ-020 SH SHALL require st_addr[0]=0; dm_web = 4'b0011 << (2*st_addr[1]), dm_wdata = {2{st_data[15:0]}}.
REQ-021 SW SHALL require st_addr[1:0]=0; dm_web = 4'b1111, dm_wdata = st_data.
REQ-022 Any other funct3 or a misaligned SH/SW SHALL be illegal: no request, no stall, st_fault high next cycle.
REQ-023 FSM states SHALL be IDLE and ISSUE only.
REQ-024 IDLE: st_valid & legal & ~CSR_reset SHALL register address, strobes and data, then go to ISSUE.
REQ-025 IDLE with CSR_reset high SHALL ignore st_valid; no request, no fault.
REQ-026 ISSUE SHALL hold dm_req_valid=1 and dm_addr/dm_wdata/dm_web stable until dm_req_ready.
REQ-027 ISSUE SHALL ignore st_valid, st_* and CSR_reset; an issued request is never withdrawn except by reset or timeout.
REQ-028 ISSUE & dm_req_ready SHALL return to IDLE; st_done high in the following cycle.
REQ-029 Latency: st_valid at cycle N, dm_req_valid at N+1; ready at N+1 gives st_done at N+2.
REQ-030 dm_stall SHALL be combinational: (IDLE & st_valid & legal & ~CSR_reset) | (ISSUE & ~dm_req_ready & ~timeout_hit).
REQ-031 Timeout counter SHALL clear on ISSUE entry and increment each ISSUE cycle without ready.
REQ-032 When counter = TIMEOUT_CYCLES-1 with no ready (timeout_hit), dm_req_valid SHALL drop next cycle, FSM returns to IDLE, st_fault pulses.
REQ-033 dm_req_ready in the timeout_hit cycle SHALL win: handshake completes, st_done pulses, no fault.
REQ-034 dm_req_valid, dm_addr, dm_wdata, dm_web SHALL be registered outputs, 0 outside ISSUE.
REQ-035 dm_req_ready outside ISSUE SHALL be ignored.

Reset
REQ-036 reset SHALL force IDLE, counter 0, and all registered outputs 0 at the next edge.
REQ-037 reset during ISSUE SHALL abandon the request without st_done or st_fault.
REQ-038 reset SHALL take priority over every other input.

Structure
REQ-039 Package dm_pkg SHALL hold the SB/SH/SW funct3 constants and the state enum.
REQ-040 Combinational lane logic SHALL be sub-module store_align (funct3, addr[1:0], data -> wdata, web, legal).
REQ-041 FSM, timeout counter and output registers SHALL stay in dm_store_ctrl.

Verification
REQ-042 SB, addr 0x1003, data 0x000000A5, ready=1 -> dm_addr 0x1000, web 4'b1000, wdata 0xA5A5A5A5, st_done at N+2.
REQ-043 SH, addr 0x2002, data 0x1234BEEF, ready low 3 cycles -> web 4'b1100, wdata 0xBEEFBEEF, request held stable, dm_stall high 4 cycles.
REQ-044 SW, addr 0x3001 -> no dm_req_valid, dm_stall 0, st_fault pulse at N+1.
REQ-045 TIMEOUT_CYCLES=4, ready tied 0 -> dm_req_valid high 4 cycles, then low, one st_fault, FSM in IDLE.
REQ-046 SW issued, CSR_reset pulsed in ISSUE, then ready -> write completes, st_done; a second st_valid with CSR_reset in IDLE -> ignored.
REQ-047 reset asserted mid-ISSUE -> all outputs 0 next cycle, no st_done or st_fault.
